commit_trace_queue: RTL and testbench
=====================================

COMMIT_TRACE_QUEUE -- requirements
Module: commit_trace_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port in_valid  input  1  commit event offered by writeback.
REQ-005 SHALL have port in_ready  output  1  queue can accept an event.
REQ-006 SHALL have ports in_npc, in_inst, in_mtvec, in_mepc  input  32 each  committed next-PC, instruction, mtvec, mepc.
REQ-007 SHALL have port flush  input  1  synchronous clear of queued events.
REQ-008 SHALL have port out_stall  input  1  tracer/host back-pressure; no pop while high.
REQ-009 SHALL have port out_en  output  1  one-cycle strobe: out_* fields valid for this cycle.
REQ-010 SHALL have ports out_npc, out_inst, out_mtvec, out_mepc  output  32 each  traced fields.
REQ-011 SHALL have port out_exec_cycle  output  64  cycles spent on this commit.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Accept (push) SHALL occur on a posedge where in_valid && in_ready && !flush.
REQ-014 in_ready SHALL equal (count != DEPTH), combinationally from registered state; no bypass when full.
REQ-015 Internal 64-bit cycle counter cnt SHALL: on accept load 0; otherwise increment, saturating at 2^64-1.
REQ-016 Each pushed entry SHALL store the four 32-bit fields plus exec_cycle = cnt+1 (saturating) sampled at the accept edge.
REQ-017 Pop SHALL occur on a posedge where count != 0 && !out_stall && !flush; the head entry is loaded into the out_* registers and out_en is set to 1 for exactly the following cycle.
REQ-018 On any posedge without a pop, out_en SHALL be 0; out_* data registers hold their last value.
REQ-019 At most one push and one pop per cycle; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-020 Entries SHALL be emitted strictly in accept order; read/write pointers wrap modulo DEPTH.
REQ-021 Minimum latency SHALL be 2 edges: accept at edge t -> out_en high in the cycle after edge t+1.
REQ-022 Back-to-back pops SHALL give out_en high on consecutive cycles (1 event/cycle throughput).
REQ-023 flush SHALL have priority over push and pop: on that edge pointers and count go to 0, out_en goes to 0, in_valid ignored; cnt SHALL continue counting (not cleared).
REQ-024 out_stall rising with an event already on out_* SHALL NOT cancel that strobe; it only blocks subsequent pops.
REQ-025 Pushing when full is impossible by REQ-014; in_valid while !in_ready SHALL NOT alter state or cnt except normal increment.

Reset
REQ-026 While reset is low, asynchronously: count=0, pointers=0, cnt=0, out_en=0, all out_* data outputs=0; in_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries and any pending strobe immediately; no out_en after release until a new accept and pop.
REQ-028 First accept in the first cycle after reset release SHALL record exec_cycle=1.

Verification
REQ-029 Reset release, in_valid=1 one cycle with npc=0x80000004, inst=0x00000013 -> two edges later out_en=1 one cycle, out_npc=0x80000004, out_inst=0x00000013, out_exec_cycle=1.
REQ-030 Accepts at cycles 1, 2, 7 after reset -> out_exec_cycle sequence 1, 1, 5, emitted in order.
REQ-031 DEPTH=4, out_stall=1, in_valid=1 for 6 cycles -> 4 accepts, count=4, in_ready=0; release stall -> 4 strobes on consecutive cycles, then in_ready=1.
REQ-032 count=3, flush=1 with in_valid=1 same cycle -> next cycle count=0, out_en=0, nothing later emitted; cnt not reset (next accept exec_cycle reflects full gap).
REQ-033 Continuous in_valid with out_stall=0 for 20 cycles -> count stays at most 1, 20 strobes each with exec_cycle=1, pointer wrap exercised.
REQ-034 reset low while count=2 and out_en=1 -> out_en=0 and count=0 immediately; after release no spurious out_en.

Source files
------------

// File: rtl/commit_trace_queue.sv
// commit_trace_queue
//   Small in-order FIFO between writeback and an instruction tracer. Each
//   accepted commit event records npc/inst/mtvec/mepc plus the number of
//   cycles since the previous accept (exec_cycle). The head entry is popped
//   into registered out_* fields and out_en strobes for exactly one cycle.
//
// Ports
//   clock          sole clock, all state on posedge
//   reset          asynchronous, active-low
//   in_valid       commit event offered
//   in_ready       queue not full (from registered count only, no bypass)
//   in_npc/in_inst/in_mtvec/in_mepc   committed fields (32 bits each)
//   flush          synchronous clear of queued events and pending strobe
//   out_stall      tracer back-pressure, blocks pops while high
//   out_en         one-cycle strobe qualifying out_*
//   out_npc/out_inst/out_mtvec/out_mepc  traced fields
//   out_exec_cycle cycles spent on this commit
//   count          current FIFO occupancy
module commit_trace_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_npc,
    input  logic [31:0]                in_inst,
    input  logic [31:0]                in_mtvec,
    input  logic [31:0]                in_mepc,
    input  logic                       flush,
    input  logic                       out_stall,
    output logic                       out_en,
    output logic [31:0]                out_npc,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_mtvec,
    output logic [31:0]                out_mepc,
    output logic [63:0]                out_exec_cycle,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] inst;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [63:0] exec;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic [63:0]     cnt;
    logic [63:0]     cnt_inc;
    logic            full;
    logic            push;
    logic            pop;
    entry_t          head;

    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;

    // flush wins over both push and pop on the same edge
    assign push = in_valid && !full && !flush;
    assign pop  = (count_q != '0) && !out_stall && !flush;

    // saturating +1; also the exec_cycle value captured on accept
    assign cnt_inc = (cnt == {64{1'b1}}) ? cnt : cnt + 64'd1;

    assign head = mem[rd_ptr];

    // Cycles since last accept. Not touched by flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     cnt <= '0;
        else if (push)  cnt <= '0;
        else            cnt <= cnt_inc;
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{npc:   in_npc,
                              inst:  in_inst,
                              mtvec: in_mtvec,
                              mepc:  in_mepc,
                              exec:  cnt_inc};
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Output stage: strobe follows pop by one edge; data holds between pops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_en         <= 1'b0;
            out_npc        <= '0;
            out_inst       <= '0;
            out_mtvec      <= '0;
            out_mepc       <= '0;
            out_exec_cycle <= '0;
        end else begin
            out_en <= pop;
            if (pop) begin
                out_npc        <= head.npc;
                out_inst       <= head.inst;
                out_mtvec      <= head.mtvec;
                out_mepc       <= head.mepc;
                out_exec_cycle <= head.exec;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_queue.sv
// Bench for commit_trace_queue: directed table, hand sequences for stall
// fill / flush / continuous flow / mid-run reset, then random traffic,
// all against a queue-based reference model.
module tb_commit_trace_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_npc = '0, in_inst = '0, in_mtvec = '0, in_mepc = '0;
    logic        flush = 1'b0;
    logic        out_stall = 1'b0;
    logic        out_en;
    logic [31:0] out_npc, out_inst, out_mtvec, out_mepc;
    logic [63:0] out_exec_cycle;
    logic [$clog2(DEPTH):0] count;

    commit_trace_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_npc(in_npc), .in_inst(in_inst), .in_mtvec(in_mtvec), .in_mepc(in_mepc),
        .flush(flush), .out_stall(out_stall),
        .out_en(out_en), .out_npc(out_npc), .out_inst(out_inst),
        .out_mtvec(out_mtvec), .out_mepc(out_mepc),
        .out_exec_cycle(out_exec_cycle), .count(count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: exec_cycle = edges since the previous accept
    // (reset release counts as an accept at the current edge number).
    typedef struct {
        logic [31:0] npc, inst, mtvec, mepc;
        logic [63:0] exec;
    } ent_t;

    ent_t   q[$];
    ent_t   m_out;
    logic   m_en;
    longint cyc = 0;
    longint last_acc = 0;

    task automatic model_reset();
        q.delete();
        m_out = '{default: '0};
        m_en  = 1'b0;
    endtask

    task automatic check_model();
        chk("model_en",     {63'd0, out_en}, {63'd0, m_en});
        chk("model_count",  64'(count), 64'(q.size()));
        chk("model_ready",  {63'd0, in_ready}, {63'd0, q.size() != DEPTH});
        chk("model_npc",    {32'd0, out_npc},   {32'd0, m_out.npc});
        chk("model_inst",   {32'd0, out_inst},  {32'd0, m_out.inst});
        chk("model_mtvec",  {32'd0, out_mtvec}, {32'd0, m_out.mtvec});
        chk("model_mepc",   {32'd0, out_mepc},  {32'd0, m_out.mepc});
        chk("model_exec",   out_exec_cycle, m_out.exec);
    endtask

    // Drive inputs, take one edge, advance the model, check at negedge.
    task automatic step(input logic v, input logic f, input logic s,
                        input logic [31:0] npc, input logic [31:0] inst,
                        input logic [31:0] mtvec, input logic [31:0] mepc);
        bit   acc, pp;
        ent_t e;
        in_valid = v; flush = f; out_stall = s;
        in_npc = npc; in_inst = inst; in_mtvec = mtvec; in_mepc = mepc;
        @(posedge clock);
        cyc++;
        acc  = v && (q.size() != DEPTH) && !f;
        pp   = (q.size() != 0) && !s && !f;
        m_en = pp;
        if (pp) m_out = q.pop_front();
        if (f)  q.delete();
        if (acc) begin
            e.npc = npc; e.inst = inst; e.mtvec = mtvec; e.mepc = mepc;
            e.exec = 64'(cyc - last_acc);
            last_acc = cyc;
            q.push_back(e);
        end
        @(negedge clock);
        check_model();
    endtask

    task automatic idle(input logic s);
        step(1'b0, 1'b0, s, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic push_r(input logic s);
        step(1'b1, 1'b0, s, $urandom, $urandom, $urandom, $urandom);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] npc, inst;
        logic        exp_en;
        int          exp_cnt;
        logic [31:0] exp_npc, exp_inst;
        logic [63:0] exp_exec;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // edges 1..9 after release: accepts at 1, 2, 7
        tbl[0] = '{1'b1, 32'h80000004, 32'h00000013, 1'b0, 1, 32'h0,        32'h0,        64'd0};
        tbl[1] = '{1'b1, 32'h80000008, 32'h00100093, 1'b1, 1, 32'h80000004, 32'h00000013, 64'd1};
        tbl[2] = '{1'b0, 32'h0,        32'h0,        1'b1, 0, 32'h80000008, 32'h00100093, 64'd1};
        tbl[3] = '{1'b0, 32'h0,        32'h0,        1'b0, 0, 32'h80000008, 32'h00100093, 64'd1};
        tbl[4] = '{1'b0, 32'h0,        32'h0,        1'b0, 0, 32'h80000008, 32'h00100093, 64'd1};
        tbl[5] = '{1'b0, 32'h0,        32'h0,        1'b0, 0, 32'h80000008, 32'h00100093, 64'd1};
        tbl[6] = '{1'b1, 32'h8000001c, 32'h00200113, 1'b0, 1, 32'h80000008, 32'h00100093, 64'd1};
        tbl[7] = '{1'b0, 32'h0,        32'h0,        1'b1, 0, 32'h8000001c, 32'h00200113, 64'd5};
        tbl[8] = '{1'b0, 32'h0,        32'h0,        1'b0, 0, 32'h8000001c, 32'h00200113, 64'd5};

        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_en",    {63'd0, out_en}, 64'd0);
        chk("rst_npc",   {32'd0, out_npc}, 64'd0);
        chk("rst_exec",  out_exec_cycle, 64'd0);
        reset = 1'b1;
        last_acc = cyc;

        // directed table
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, 1'b0, 1'b0, tbl[i].npc, tbl[i].inst, 32'd0, 32'd0);
            chk($sformatf("tbl%0d_en", i),    {63'd0, out_en}, {63'd0, tbl[i].exp_en});
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_npc", i),   {32'd0, out_npc}, {32'd0, tbl[i].exp_npc});
            chk($sformatf("tbl%0d_inst", i),  {32'd0, out_inst}, {32'd0, tbl[i].exp_inst});
            chk($sformatf("tbl%0d_exec", i),  out_exec_cycle, tbl[i].exp_exec);
        end

        // stall fill: 6 offers under stall -> 4 accepts, then drain back to back
        for (int i = 0; i < 6; i++) push_r(1'b1);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_ready", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk($sformatf("drain%0d_en", i), {63'd0, out_en}, 64'd1);
        end
        idle(1'b0);
        chk("drain_done_en",    {63'd0, out_en}, 64'd0);
        chk("drain_done_ready", {63'd0, in_ready}, 64'd1);

        // flush with in_valid high at count=3; cnt keeps running across it
        for (int i = 0; i < 3; i++) push_r(1'b1);
        chk("pre_flush_count", 64'(count), 64'd3);
        step(1'b1, 1'b1, 1'b0, 32'hdead0000, 32'h1, 32'h2, 32'h3);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_en",    {63'd0, out_en}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk($sformatf("post_flush%0d_en", i), {63'd0, out_en}, 64'd0);
        end
        push_r(1'b0);
        idle(1'b0);
        chk("flush_gap_en",   {63'd0, out_en}, 64'd1);
        chk("flush_gap_exec", out_exec_cycle, 64'd5);

        // continuous flow, exercises pointer wrap
        for (int i = 0; i < 20; i++) begin
            push_r(1'b0);
            chk($sformatf("flow%0d_count", i), 64'(count), 64'd1);
            if (i >= 1) chk($sformatf("flow%0d_en", i), {63'd0, out_en}, 64'd1);
            if (i >= 2) chk($sformatf("flow%0d_exec", i), out_exec_cycle, 64'd1);
        end
        idle(1'b0);
        idle(1'b0);

        // asynchronous reset with count=2 and a strobe in flight
        for (int i = 0; i < 3; i++) push_r(1'b1);
        idle(1'b0);
        chk("pre_rst_count", 64'(count), 64'd2);
        chk("pre_rst_en",    {63'd0, out_en}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_en",    {63'd0, out_en}, 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("async_rst_npc",   {32'd0, out_npc}, 64'd0);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        last_acc = cyc;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk($sformatf("post_rst%0d_en", i), {63'd0, out_en}, 64'd0);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 3),
                 $urandom, $urandom, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
